noc_input_fifo: RTL and testbench

- Per-port input buffer of the NoC router; sits directly upstream of the LBDR routing stage.
- Accepts flits from the neighbouring router or NI under credit-based flow control, stores them in a circular first-word-fall-through FIFO, and presents the head flit to LBDR as empty, flit_id and dst_addr.
- Returns one credit per flit consumed.
- Tracks packet framing (header/body/tail) and flags protocol violations.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/noc_fifo_mem.sv | 24 ++
 rtl/noc_input_fifo.sv | 110 +++++++++++
 tb/tb_noc_input_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared flit encodings and framing types for the NoC input port.
package noc_pkg;

   localparam logic [2:0] FLIT_HEADER = 3'b001;
   localparam logic [2:0] FLIT_BODY   = 3'b010;
   localparam logic [2:0] FLIT_TAIL   = 3'b100;

   localparam int FLIT_ID_MSB = 31;
   localparam int FLIT_ID_LSB = 29;
   localparam int DST_MSB     = 3;
   localparam int DST_LSB     = 0;

   typedef logic [2:0] flit_id_t;

   typedef enum logic {
      IDLE,
      PKT
   } state_t;

endpackage

// File: rtl/noc_fifo_mem.sv
// Flit storage: one synchronous write port, one asynchronous read port.
module noc_fifo_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_WIDTH-1:0]    rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/noc_input_fifo.sv
// Router input buffer: FWFT flit FIFO with credit return and framing check.
module noc_input_fifo
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   input  logic [DATA_WIDTH-1:0]    flit_in,
   input  logic                     read_en,
   output logic                     credit_out,
   output logic                     empty,
   output flit_id_t                 flit_id,
   output logic [3:0]               dst_addr,
   output logic [DATA_WIDTH-1:0]    flit_out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err_overflow,
   output logic                     err_proto
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          full;
   logic          pop;
   logic          push;
   logic [3:0]    dst_reg;
   logic [3:0]    head_dst;
   state_t        state;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign pop   = read_en & ~empty;
   assign push  = valid_in & (~full | pop);

   noc_fifo_mem #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
   ) u_mem (
      .clk  (clk),
      .we   (push),
      .waddr(wr_ptr),
      .wdata(flit_in),
      .raddr(rd_ptr),
      .rdata(flit_out)
   );

   assign flit_id  = flit_out[FLIT_ID_MSB:FLIT_ID_LSB];
   assign head_dst = flit_out[DST_MSB:DST_LSB];

   // A header at the head announces its destination before it is popped
   assign dst_addr = (!empty && flit_id == FLIT_HEADER) ? head_dst : dst_reg;

   // Pointers are AW bits wide, so DEPTH-1 -> 0 wrap is natural
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         credit_out   <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count      <= count + CW'(push) - CW'(pop);
         credit_out <= pop;
         if (valid_in & full & ~pop) begin
            err_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         dst_reg   <= '0;
         err_proto <= 1'b0;
      end else if (pop) begin
         if (flit_id == FLIT_HEADER) begin
            dst_reg <= head_dst;
         end
         case (state)
            IDLE: begin
               if (flit_id == FLIT_HEADER) begin
                  state <= PKT;
               end else begin
                  err_proto <= 1'b1;
               end
            end
            PKT: begin
               if (flit_id == FLIT_TAIL) begin
                  state <= IDLE;
               end else if (flit_id != FLIT_BODY) begin
                  err_proto <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_input_fifo.sv
// Randomized and directed bench for noc_input_fifo against a queue model.
module tb_noc_input_fifo;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] flit_in = '0;
   logic        read_en = 1'b0;
   logic        credit_out;
   logic        empty;
   logic [2:0]  flit_id;
   logic [3:0]  dst_addr;
   logic [31:0] flit_out;
   logic [2:0]  count;
   logic        err_overflow;
   logic        err_proto;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] q[$];
   logic        m_ovf;
   logic        m_proto;
   logic        m_inpkt;
   logic [3:0]  m_dst;
   logic        m_cred;

   noc_input_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .valid_in    (valid_in),
      .flit_in     (flit_in),
      .read_en     (read_en),
      .credit_out  (credit_out),
      .empty       (empty),
      .flit_id     (flit_id),
      .dst_addr    (dst_addr),
      .flit_out    (flit_out),
      .count       (count),
      .err_overflow(err_overflow),
      .err_proto   (err_proto)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare();
      logic [3:0] ed;
      logic [31:0] h;
      ed = m_dst;
      if (q.size() > 0) begin
         h = q[0];
         if (h[31:29] == 3'b001) ed = h[3:0];
      end
      chk("empty", empty, q.size() == 0);
      chk("count", count, q.size());
      chk("credit", credit_out, m_cred);
      chk("err_ovf", err_overflow, m_ovf);
      chk("err_proto", err_proto, m_proto);
      chk("dst_addr", dst_addr, ed);
      if (q.size() > 0) begin
         chk("flit_out", flit_out, h);
         chk("flit_id", flit_id, h[31:29]);
      end
   endtask

   task automatic model(input logic v, input logic [31:0] f, input logic r);
      logic pop, push, full;
      logic [31:0] h;
      logic [2:0] id;
      if (!rst) begin
         q.delete();
         m_ovf = 0; m_proto = 0; m_inpkt = 0; m_dst = 0; m_cred = 0;
         return;
      end
      pop  = r && q.size() > 0;
      full = q.size() == DEPTH;
      push = v && (!full || pop);
      if (v && full && !pop) m_ovf = 1;
      if (pop) begin
         h  = q.pop_front();
         id = h[31:29];
         if (id == 3'b001) m_dst = h[3:0];
         if (!m_inpkt) begin
            if (id == 3'b001) m_inpkt = 1;
            else m_proto = 1;
         end else begin
            if (id == 3'b100) m_inpkt = 0;
            else if (id != 3'b010) m_proto = 1;
         end
      end
      if (push) q.push_back(f);
      m_cred = pop;
   endtask

   task automatic step(input logic v, input logic [31:0] f, input logic r);
      @(negedge clk);
      valid_in = v; flit_in = f; read_en = r;
      #1;
      compare();
      model(v, f, r);
      @(posedge clk);
      #1;
      valid_in = 0; read_en = 0;
   endtask

   task automatic do_reset(input int n);
      rst = 0;
      for (int i = 0; i < n; i++) step(0, 32'h0, 0);
      rst = 1;
   endtask

   function automatic logic [31:0] mk(input logic [2:0] id, input logic [28:0] p);
      return {id, p};
   endfunction

   initial begin
      logic [31:0] rv;
      logic [2:0]  gid;
      logic        gph;
      logic        v, r;

      m_ovf = 0; m_proto = 0; m_inpkt = 0; m_dst = 0; m_cred = 0;

      // reset then single header
      do_reset(2);
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);
      chk("rst_credit", credit_out, 0);
      step(1, 32'h2000_0009, 0);
      chk("hdr_empty", empty, 0);
      chk("hdr_id", flit_id, 3'b001);
      chk("hdr_dst", dst_addr, 4'h9);
      chk("hdr_count", count, 1);

      // full packet with read_en held
      do_reset(1);
      step(1, 32'h2000_0006, 1);
      step(1, 32'h4000_00ab, 1);
      chk("pkt_dst_hdr", dst_addr, 4'h6);
      step(1, 32'h4000_00cd, 1);
      chk("pkt_dst_body", dst_addr, 4'h6);
      step(1, 32'h8000_00ef, 1);
      chk("pkt_credit", credit_out, 1);
      step(0, 32'h0, 1);
      chk("pkt_dst_tail", dst_addr, 4'h6);
      for (int i = 0; i < 3; i++) step(0, 32'h0, 1);
      chk("pkt_proto", err_proto, 0);
      chk("pkt_empty", empty, 1);

      // fill and overflow
      do_reset(1);
      step(1, 32'h2000_0001, 0);
      step(1, 32'h4000_0002, 0);
      step(1, 32'h4000_0003, 0);
      step(1, 32'h4000_0004, 0);
      step(1, 32'h8000_0005, 0);
      chk("ovf_count", count, 4);
      chk("ovf_flag", err_overflow, 1);
      for (int i = 0; i < 4; i++) step(0, 32'h0, 1);
      chk("ovf_drain", empty, 1);
      step(0, 32'h0, 1);

      // simultaneous push/pop at full, with wrap
      do_reset(1);
      step(1, 32'h2000_0003, 0);
      for (int i = 0; i < 3; i++) step(1, mk(3'b010, 29'(i)), 0);
      for (int i = 0; i < 4; i++) step(1, mk(3'b010, 29'(16 + i)), 1);
      chk("pp_count", count, 4);
      chk("pp_ovf", err_overflow, 0);
      for (int i = 0; i < 5; i++) step(0, 32'h0, 1);

      // protocol errors
      do_reset(1);
      step(1, 32'h4000_0000, 0);
      step(0, 32'h0, 1);
      step(0, 32'h0, 0);
      chk("pe_body", err_proto, 1);
      do_reset(1);
      step(1, 32'h2000_0001, 0);
      step(1, 32'h2000_0002, 1);
      step(0, 32'h0, 1);
      step(0, 32'h0, 0);
      chk("pe_hh", err_proto, 1);
      chk("pe_hh_dst", dst_addr, 4'h2);
      do_reset(1);
      step(1, 32'h6000_0000, 0);
      step(0, 32'h0, 1);
      step(0, 32'h0, 0);
      chk("pe_ill", err_proto, 1);

      // reset mid-packet
      do_reset(1);
      step(1, 32'h2000_0004, 0);
      step(1, 32'h4000_0004, 0);
      rst = 0;
      step(1, 32'h4000_0005, 1);
      rst = 1;
      chk("mr_empty", empty, 1);
      chk("mr_count", count, 0);
      chk("mr_credit", credit_out, 0);
      chk("mr_proto", err_proto, 0);
      step(0, 32'h0, 0);

      // randomized traffic
      gph = 0;
      for (int c = 0; c < 800; c++) begin
         if (c % 100 == 0) do_reset(1 + $urandom_range(0, 1));
         v = ($urandom_range(0, 99) < 60);
         r = ($urandom_range(0, 99) < 55);
         rv = $urandom();
         if ($urandom_range(0, 29) == 0) gid = 3'($urandom_range(0, 7));
         else if (!gph) gid = 3'b001;
         else if ($urandom_range(0, 2) == 0) gid = 3'b100;
         else gid = 3'b010;
         if (v) begin
            if (gid == 3'b001) gph = 1;
            else if (gid == 3'b100) gph = 0;
         end
         rv[31:29] = gid;
         step(v, rv, r);
      end
      step(0, 32'h0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
